present_byte_loader: RTL and testbench

Byte-stream front end for the serial PRESENT-80 core. It accepts a command/data byte stream over a valid/ready handshake and loads the 80-bit key and 64-bit plaintext into the core one byte lane at a time, using the core's per-byte register enables. It then starts the encryption, waits for the core to finish, captures the 64-bit ciphertext and streams it back out byte by byte. It sits directly upstream of the core (and downstream of the chip's byte I/O pins).

---
 rtl/present_byte_loader.sv | 161 ++++++++++++++++
 tb/tb_present_byte_loader.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/present_byte_loader.sv
// Byte-stream front end for the serial PRESENT-80 core: loads key/plaintext
// lanes from a command byte stream, starts the core and streams the ciphertext back.
module present_byte_loader (
   input  logic        Clk_ik,
   input  logic        Reset_ir,
   input  logic [7:0]  InData_ib,
   input  logic        InValid_i,
   output logic        InReady_o,
   output logic [7:0]  OutData_ob,
   output logic        OutValid_o,
   input  logic        OutReady_i,
   output logic        KeyLoaded_o,
   output logic        CmdError_o,
   output logic [63:0] CorePlainText_ob,
   output logic [79:0] CoreKey_ob,
   output logic [7:0]  CoreTextEnable_ob,
   output logic [9:0]  CoreKeyEnable_ob,
   output logic        CoreStart_o,
   input  logic        CoreReady_i,
   input  logic [63:0] CoreCipherText_ib,
   output logic        CoreReset_or
);

   localparam logic [7:0] CMD_KEY  = 8'h4B;
   localparam logic [7:0] CMD_TEXT = 8'h54;

   typedef enum logic [2:0] {IDLE, KEY, TEXT, START, WAIT, OUT} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [63:0] shift_q, shift_d;
   logic        in_ready_q, in_ready_d;
   logic        out_valid_q, out_valid_d;
   logic        key_loaded_q, key_loaded_d;
   logic        cmd_error_q, cmd_error_d;
   logic        start_q, start_d;
   logic        core_reset_q;
   logic        in_fire;
   logic        out_fire;

   assign in_fire  = InValid_i & in_ready_q;
   assign out_fire = out_valid_q & OutReady_i;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      shift_d      = shift_q;
      out_valid_d  = out_valid_q;
      key_loaded_d = key_loaded_q;
      cmd_error_d  = 1'b0;
      start_d      = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_fire) begin
               if (InData_ib == CMD_KEY) begin
                  state_d = KEY;
                  cnt_d   = 4'd9;
               end else if ((InData_ib == CMD_TEXT) && key_loaded_q) begin
                  state_d = TEXT;
                  cnt_d   = 4'd7;
               end else begin
                  cmd_error_d = 1'b1;
               end
            end
         end
         KEY: begin
            if (in_fire) begin
               if (cnt_q == 4'd0) begin
                  key_loaded_d = 1'b1;
                  state_d      = IDLE;
               end else begin
                  cnt_d = cnt_q - 4'd1;
               end
            end
         end
         TEXT: begin
            if (in_fire) begin
               if (cnt_q == 4'd0) begin
                  state_d = START;
                  start_d = 1'b1;
               end else begin
                  cnt_d = cnt_q - 4'd1;
               end
            end
         end
         START: begin
            // The core turns its key register into round keys, so the key is spent.
            key_loaded_d = 1'b0;
            state_d      = WAIT;
         end
         WAIT: begin
            if (CoreReady_i) begin
               shift_d     = CoreCipherText_ib;
               cnt_d       = 4'd7;
               out_valid_d = 1'b1;
               state_d     = OUT;
            end
         end
         OUT: begin
            if (out_fire) begin
               shift_d = {shift_q[55:0], 8'h00};
               if (cnt_q == 4'd0) begin
                  out_valid_d = 1'b0;
                  state_d     = IDLE;
               end else begin
                  cnt_d = cnt_q - 4'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      in_ready_d = (state_d == IDLE) || (state_d == KEY) || (state_d == TEXT);
   end

   always_ff @(posedge Clk_ik or posedge Reset_ir) begin
      if (Reset_ir) begin
         state_q      <= IDLE;
         cnt_q        <= 4'd0;
         shift_q      <= 64'd0;
         in_ready_q   <= 1'b0;
         out_valid_q  <= 1'b0;
         key_loaded_q <= 1'b0;
         cmd_error_q  <= 1'b0;
         start_q      <= 1'b0;
         core_reset_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         shift_q      <= shift_d;
         in_ready_q   <= in_ready_d;
         out_valid_q  <= out_valid_d;
         key_loaded_q <= key_loaded_d;
         cmd_error_q  <= cmd_error_d;
         start_q      <= start_d;
         core_reset_q <= 1'b0;
      end
   end

   // Lane enables must hit the core in the same cycle the byte is accepted.
   always_comb begin
      CoreKeyEnable_ob  = 10'd0;
      CoreTextEnable_ob = 8'd0;
      if (in_fire && (state_q == KEY)) begin
         CoreKeyEnable_ob = 10'(1) << cnt_q;
      end
      if (in_fire && (state_q == TEXT)) begin
         CoreTextEnable_ob = 8'(1) << cnt_q[2:0];
      end
   end

   assign InReady_o        = in_ready_q;
   assign OutValid_o       = out_valid_q;
   assign OutData_ob       = shift_q[63:56];
   assign KeyLoaded_o      = key_loaded_q;
   assign CmdError_o       = cmd_error_q;
   assign CoreStart_o      = start_q;
   assign CoreReset_or     = core_reset_q;
   assign CoreKey_ob       = {10{InData_ib}};
   assign CorePlainText_ob = {8{InData_ib}};

endmodule

// File: tb/tb_present_byte_loader.sv
// Bench for present_byte_loader with a behavioural PRESENT-80 core model
// and a ciphertext byte scoreboard.
module tb_present_byte_loader;

   logic        Clk_ik = 1'b0;
   logic        Reset_ir;
   logic [7:0]  InData_ib;
   logic        InValid_i;
   logic        InReady_o;
   logic [7:0]  OutData_ob;
   logic        OutValid_o;
   logic        OutReady_i;
   logic        KeyLoaded_o;
   logic        CmdError_o;
   logic [63:0] CorePlainText_ob;
   logic [79:0] CoreKey_ob;
   logic [7:0]  CoreTextEnable_ob;
   logic [9:0]  CoreKeyEnable_ob;
   logic        CoreStart_o;
   logic        CoreReady_i = 1'b1;
   logic [63:0] CoreCipherText_ib = 64'd0;
   logic        CoreReset_or;

   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   int          last_acc = 0;
   int          first_valid_cyc = 0;
   bit          seen_valid = 1'b0;
   bit          bp_en = 1'b0;
   bit          stalled = 1'b0;
   logic [7:0]  held = 8'd0;
   logic [7:0]  exp_q[$];

   logic [79:0] core_key = 80'd0;
   logic [63:0] core_text = 64'd0;
   logic        core_busy = 1'b0;
   int          core_cnt = 0;

   present_byte_loader dut (
      .Clk_ik(Clk_ik), .Reset_ir(Reset_ir),
      .InData_ib(InData_ib), .InValid_i(InValid_i), .InReady_o(InReady_o),
      .OutData_ob(OutData_ob), .OutValid_o(OutValid_o), .OutReady_i(OutReady_i),
      .KeyLoaded_o(KeyLoaded_o), .CmdError_o(CmdError_o),
      .CorePlainText_ob(CorePlainText_ob), .CoreKey_ob(CoreKey_ob),
      .CoreTextEnable_ob(CoreTextEnable_ob), .CoreKeyEnable_ob(CoreKeyEnable_ob),
      .CoreStart_o(CoreStart_o), .CoreReady_i(CoreReady_i),
      .CoreCipherText_ib(CoreCipherText_ib), .CoreReset_or(CoreReset_or)
   );

   always #5 Clk_ik = ~Clk_ik;

   always @(posedge Clk_ik) cyc++;

   function automatic logic [3:0] sbox(input logic [3:0] x);
      case (x)
         4'h0: return 4'hC;  4'h1: return 4'h5;  4'h2: return 4'h6;  4'h3: return 4'hB;
         4'h4: return 4'h9;  4'h5: return 4'h0;  4'h6: return 4'hA;  4'h7: return 4'hD;
         4'h8: return 4'h3;  4'h9: return 4'hE;  4'hA: return 4'hF;  4'hB: return 4'h8;
         4'hC: return 4'h4;  4'hD: return 4'h7;  4'hE: return 4'h1;  default: return 4'h2;
      endcase
   endfunction

   function automatic logic [63:0] present80(input logic [79:0] key_in, input logic [63:0] pt);
      logic [79:0] k;
      logic [63:0] s, t, p;
      k = key_in;
      s = pt;
      for (int r = 1; r <= 31; r++) begin
         s = s ^ k[79:16];
         for (int j = 0; j < 16; j++) t[4*j +: 4] = sbox(s[4*j +: 4]);
         p = 64'd0;
         for (int i = 0; i < 63; i++) p[(i*16) % 63] = t[i];
         p[63] = t[63];
         s = p;
         k = {k[18:0], k[79:19]};
         k[79:76] = sbox(k[79:76]);
         k[19:15] = k[19:15] ^ 5'(r);
      end
      return s ^ k[79:16];
   endfunction

   // Core model: per-lane loads, 32 busy edges after Start, synchronous reset.
   always @(posedge Clk_ik) begin
      if (CoreReset_or) begin
         core_busy   <= 1'b0;
         CoreReady_i <= 1'b1;
         core_cnt    <= 0;
      end else begin
         for (int i = 0; i < 10; i++)
            if (CoreKeyEnable_ob[i]) core_key[8*i +: 8] <= CoreKey_ob[8*i +: 8];
         for (int i = 0; i < 8; i++)
            if (CoreTextEnable_ob[i]) core_text[8*i +: 8] <= CorePlainText_ob[8*i +: 8];
         if (CoreStart_o) begin
            core_busy   <= 1'b1;
            CoreReady_i <= 1'b0;
            core_cnt    <= 0;
         end else if (core_busy) begin
            if (core_cnt == 31) begin
               core_busy         <= 1'b0;
               CoreReady_i       <= 1'b1;
               CoreCipherText_ib <= present80(core_key, core_text);
            end else begin
               core_cnt <= core_cnt + 1;
            end
         end
      end
   end

   task automatic check_output(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Output side: drive backpressure, then score each byte that will transfer.
   always @(negedge Clk_ik) begin
      if (bp_en) OutReady_i = 1'($urandom_range(0, 1));
      else       OutReady_i = 1'b1;
      if (Reset_ir) begin
         stalled = 1'b0;
      end else if (OutValid_o) begin
         if (!seen_valid) begin
            seen_valid      = 1'b1;
            first_valid_cyc = cyc;
         end
         if (stalled) check_output("out_hold", OutData_ob, held);
         if (OutReady_i) begin
            checks++;
            assert (exp_q.size() > 0) else begin
               errors++;
               $error("[TB] FAIL out_extra: observed byte=%h expected=no byte", OutData_ob);
            end
            if (exp_q.size() > 0) check_output("out_byte", OutData_ob, exp_q.pop_front());
            stalled = 1'b0;
         end else begin
            stalled = 1'b1;
            held    = OutData_ob;
         end
      end
   end

   task automatic apply_stimulus(input logic [7:0] b, input int gap_max,
                                 input logic [9:0] exp_key_en, input logic [7:0] exp_text_en,
                                 input logic exp_err);
      int gap;
      bit done;
      gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      InValid_i = 1'b0;
      repeat (gap) begin
         @(negedge Clk_ik);
         #1;
         check_output("gap_en", {62'd0, CoreKeyEnable_ob, CoreTextEnable_ob}, 80'd0);
      end
      InData_ib = b;
      InValid_i = 1'b1;
      done      = 1'b0;
      for (int n = 0; n < 100 && !done; n++) begin
         #1;
         if (InReady_o) begin
            check_output("lane_en", {62'd0, CoreKeyEnable_ob, CoreTextEnable_ob},
                         {62'd0, exp_key_en, exp_text_en});
            done = 1'b1;
         end
         @(negedge Clk_ik);
      end
      InValid_i = 1'b0;
      checks++;
      assert (done) else begin
         errors++;
         $error("[TB] FAIL in_timeout: observed=no accept expected=accept of %h", b);
      end
      if (done) begin
         last_acc = cyc;
         #1;
         check_output("cmd_err", CmdError_o, exp_err);
      end
   endtask

   task automatic do_reset();
      #2;
      Reset_ir = 1'b1;
      exp_q.delete();
      #1;
      check_output("reset_outs",
                   {InReady_o, OutValid_o, OutData_ob, KeyLoaded_o, CmdError_o, CoreStart_o,
                    CoreKeyEnable_ob, CoreTextEnable_ob, CoreReset_or},
                   {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 10'd0, 8'd0, 1'b1});
      repeat (2) @(negedge Clk_ik);
      Reset_ir = 1'b0;
      #1;
      check_output("core_rst_hold", CoreReset_or, 1'b1);
      @(negedge Clk_ik);
      #1;
      check_output("post_reset", {InReady_o, CoreReset_or, KeyLoaded_o}, 3'b100);
   endtask

   task automatic load_key(input logic [7:0] kb, input int gap_max, input logic exp_kl);
      apply_stimulus(8'h4B, gap_max, 10'd0, 8'd0, 1'b0);
      check_output("kl_during", KeyLoaded_o, exp_kl);
      for (int lane = 9; lane >= 0; lane--)
         apply_stimulus(kb, gap_max, 10'(1) << lane, 8'd0, 1'b0);
      check_output("key_loaded", KeyLoaded_o, 1'b1);
   endtask

   task automatic load_text(input logic [7:0] tb, input logic [63:0] exp, input int gap_max);
      bit got;
      for (int i = 7; i >= 0; i--) exp_q.push_back(exp[8*i +: 8]);
      seen_valid = 1'b0;
      apply_stimulus(8'h54, gap_max, 10'd0, 8'd0, 1'b0);
      for (int lane = 7; lane >= 0; lane--)
         apply_stimulus(tb, gap_max, 10'd0, 8'(1) << lane, 1'b0);
      check_output("start_pulse", {CoreStart_o, InReady_o}, 2'b10);
      @(negedge Clk_ik);
      #1;
      check_output("start_done", {CoreStart_o, KeyLoaded_o}, 2'b00);
      got = 1'b0;
      for (int n = 0; n < 400 && !got; n++) begin
         @(negedge Clk_ik);
         #2;
         got = seen_valid && (exp_q.size() == 0);
      end
      checks++;
      assert (got) else begin
         errors++;
         $error("[TB] FAIL out_timeout: observed=%0d bytes left expected=0", exp_q.size());
      end
      check_output("latency", 80'(first_valid_cyc - last_acc), 80'd34);
      @(negedge Clk_ik);
      #1;
      check_output("post_run", {InReady_o, OutValid_o, KeyLoaded_o}, 3'b100);
   endtask

   initial begin
      Reset_ir   = 1'b1;
      InValid_i  = 1'b0;
      InData_ib  = 8'h00;
      OutReady_i = 1'b1;
      @(negedge Clk_ik);
      do_reset();

      $display("[TB] zero key, zero text");
      load_key(8'h00, 0, 1'b0);
      load_text(8'h00, 64'h5579C1387B228445, 0);

      $display("[TB] ones key, zero text");
      load_key(8'hFF, 0, 1'b0);
      load_text(8'h00, 64'hE72C46C0F5945049, 0);

      $display("[TB] text without key, then zero key, ones text");
      apply_stimulus(8'h54, 0, 10'd0, 8'd0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge Clk_ik);
         #1;
         check_output("no_start", {CmdError_o, CoreStart_o, InReady_o}, 3'b001);
      end
      load_key(8'h00, 0, 1'b0);
      load_text(8'hFF, 64'hA112FFC72F68417B, 0);

      $display("[TB] bad commands");
      apply_stimulus(8'h00, 0, 10'd0, 8'd0, 1'b1);
      apply_stimulus(8'h54, 0, 10'd0, 8'd0, 1'b1);

      $display("[TB] key overwrite, gaps and backpressure");
      bp_en = 1'b1;
      load_key(8'h00, 3, 1'b0);
      load_key(8'hFF, 3, 1'b1);
      load_text(8'hFF, 64'h3333DCD3213210D2, 3);
      bp_en = 1'b0;

      $display("[TB] reset during WAIT");
      load_key(8'h00, 0, 1'b0);
      apply_stimulus(8'h54, 0, 10'd0, 8'd0, 1'b0);
      for (int lane = 7; lane >= 0; lane--)
         apply_stimulus(8'h00, 0, 10'd0, 8'(1) << lane, 1'b0);
      repeat (10) @(negedge Clk_ik);
      do_reset();
      load_key(8'h00, 0, 1'b0);
      load_text(8'h00, 64'h5579C1387B228445, 0);

      $display("[TB] reset during key load");
      apply_stimulus(8'h4B, 0, 10'd0, 8'd0, 1'b0);
      for (int lane = 9; lane >= 5; lane--)
         apply_stimulus(8'hFF, 0, 10'(1) << lane, 8'd0, 1'b0);
      do_reset();
      apply_stimulus(8'h54, 0, 10'd0, 8'd0, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
